// File: rtl/sdram_dev_lite_if.sv
// SDRAM pad-side bus between a controller (master) and the device emulator (slave).
// Command, address, mask and write data flow to the device; read data and bus enable flow back.
interface sdram_dev_lite_if;
   logic        sdr_cke;
   logic        sdr_cs_n;
   logic        sdr_ras_n;
   logic        sdr_cas_n;
   logic        sdr_we_n;
   logic [1:0]  sdr_ba;
   logic [12:0] sdr_addr;
   logic        sdr_dqm;
   logic [7:0]  sdr_din;
   logic [7:0]  sdr_dout;
   logic        sdr_doe;

   modport master (
      output sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
      output sdr_ba, sdr_addr, sdr_dqm, sdr_din,
      input  sdr_dout, sdr_doe
   );

   modport slave (
      input  sdr_cke, sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n,
      input  sdr_ba, sdr_addr, sdr_dqm, sdr_din,
      output sdr_dout, sdr_doe
   );
endinterface

// File: rtl/sdram_dev_lite.sv
// 8-bit SDR SDRAM device emulator: decodes pad commands, tracks open rows per bank and
// runs sequential read/write bursts against an internal byte array with CAS latency 2 or 3.
module sdram_dev_lite #(
   parameter int COL_W = 8,
   parameter int ROW_W = 2
) (
   input  logic            clk,
   input  logic            reset,
   sdram_dev_lite_if.slave sdr,
   output logic [12:0]     mode_reg,
   output logic [15:0]     rfsh_cnt,
   output logic            cmd_err
);
   localparam int AW = 2 + ROW_W + COL_W;

   typedef enum logic [2:0] {
      CMD_MRS = 3'b000,
      CMD_REF = 3'b001,
      CMD_PRE = 3'b010,
      CMD_ACT = 3'b011,
      CMD_WR  = 3'b100,
      CMD_RD  = 3'b101,
      CMD_BST = 3'b110,
      CMD_NOP = 3'b111
   } cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE
   } bst_state_e;

   typedef struct packed {
      logic          vld;
      logic          cl2;
      logic [AW-1:0] idx;
   } rd_beat_t;

   // Device state
   logic [12:0]      r_mode;
   logic [15:0]      r_rfsh;
   logic             r_err;
   logic [3:0]       r_bank_open;
   logic [ROW_W-1:0] r_open_row [4];

   // Burst state
   bst_state_e       r_state;
   bst_state_e       w_state_nxt;
   logic [1:0]       r_bst_ba;
   logic [ROW_W-1:0] r_bst_row;
   logic [COL_W-1:0] r_bst_start;
   logic [COL_W-1:0] r_bst_cnt;
   logic [COL_W-1:0] r_bst_last;
   logic             r_bst_ap;

   // Read pipeline and registered pad outputs
   rd_beat_t         r_p1;
   rd_beat_t         r_p2;
   logic             r_dqm_d;
   logic [7:0]       r_dout;
   logic             r_doe;
   logic [7:0]       r_mem [2**AW];

   // Decode
   cmd_e             w_cmd;
   logic             w_cmd_vld;
   logic             w_is_bst;
   logic             w_pre_hit;
   logic             w_new_rd;
   logic             w_new_wr;
   logic             w_cl2;
   logic [COL_W-1:0] w_bl_last;
   logic [COL_W-1:0] w_wr_last;

   // Beat issued this cycle
   logic             w_beat;
   logic             w_beat_wr;
   logic [1:0]       w_ba;
   logic [ROW_W-1:0] w_row;
   logic [COL_W-1:0] w_start;
   logic [COL_W-1:0] w_cnt;
   logic [COL_W-1:0] w_last;
   logic             w_ap;
   logic [COL_W-1:0] w_cnt_nxt;
   logic             w_close;
   logic [COL_W-1:0] w_col;
   logic [AW-1:0]    w_idx;
   logic             w_out_vld;
   logic [AW-1:0]    w_out_idx;

   assign w_cmd     = cmd_e'({sdr.sdr_ras_n, sdr.sdr_cas_n, sdr.sdr_we_n});
   assign w_cmd_vld = sdr.sdr_cke && !sdr.sdr_cs_n;
   assign w_is_bst  = w_cmd_vld && (w_cmd == CMD_BST);
   assign w_pre_hit = w_cmd_vld && (w_cmd == CMD_PRE) &&
                      (sdr.sdr_addr[10] || (sdr.sdr_ba == r_bst_ba));
   assign w_new_rd  = w_cmd_vld && (w_cmd == CMD_RD) && r_bank_open[sdr.sdr_ba];
   assign w_new_wr  = w_cmd_vld && (w_cmd == CMD_WR) && r_bank_open[sdr.sdr_ba];
   assign w_cl2     = (r_mode[6:4] == 3'd2);

   // Burst length minus one doubles as the wrap mask for the aligned block
   always_comb begin
      unique case (r_mode[2:0])
         3'd0:    w_bl_last = '0;
         3'd1:    w_bl_last = COL_W'(1);
         3'd2:    w_bl_last = COL_W'(3);
         3'd3:    w_bl_last = COL_W'(7);
         3'd7:    w_bl_last = {COL_W{1'b1}};
         default: w_bl_last = '0;
      endcase
   end

   assign w_wr_last = r_mode[9] ? '0 : w_bl_last;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no latch is inferred.
      w_state_nxt = r_state;
      w_beat      = 1'b0;
      w_beat_wr   = 1'b0;
      w_ba        = r_bst_ba;
      w_row       = r_bst_row;
      w_start     = r_bst_start;
      w_cnt       = r_bst_cnt;
      w_last      = r_bst_last;
      w_ap        = r_bst_ap;
      w_cnt_nxt   = r_bst_cnt;
      w_close     = 1'b0;
      if (w_new_rd || w_new_wr) begin
         w_beat    = 1'b1;
         w_beat_wr = w_new_wr;
         w_ba      = sdr.sdr_ba;
         w_row     = r_open_row[sdr.sdr_ba];
         w_start   = sdr.sdr_addr[COL_W-1:0];
         w_cnt     = '0;
         w_last    = w_new_wr ? w_wr_last : w_bl_last;
         w_ap      = sdr.sdr_addr[10];
      end else if (sdr.sdr_cke && (r_state != ST_IDLE) && !w_is_bst && !w_pre_hit) begin
         w_beat    = 1'b1;
         w_beat_wr = (r_state == ST_WRITE);
      end
      if (w_beat) begin
         if (w_cnt == w_last) begin
            w_state_nxt = ST_IDLE;
            w_close     = w_ap;
         end else begin
            w_state_nxt = w_beat_wr ? ST_WRITE : ST_READ;
            w_cnt_nxt   = w_cnt + COL_W'(1);
         end
      end else if (w_is_bst || w_pre_hit) begin
         w_state_nxt = ST_IDLE;
      end
   end

   assign w_col = (w_start & ~w_last) | ((w_start + w_cnt) & w_last);
   assign w_idx = {w_ba, w_row, w_col};

   // A CL2 beat leaves from stage 1, a CL3 beat one cycle later from stage 2
   assign w_out_vld = r_p2.vld || (r_p1.vld && r_p1.cl2);
   assign w_out_idx = r_p2.vld ? r_p2.idx : r_p1.idx;

   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state always uses non-blocking assignments so every register
      // samples the pre-edge values regardless of block ordering.
      if (reset) begin
         r_state <= ST_IDLE;
      end else if (sdr.sdr_cke) begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mode      <= 13'h032;
         r_rfsh      <= '0;
         r_err       <= 1'b0;
         r_bank_open <= '0;
         for (int i = 0; i < 4; i++) r_open_row[i] <= '0;
      end else if (sdr.sdr_cke) begin
         if (w_close) r_bank_open[w_ba] <= 1'b0;
         if (w_cmd_vld) begin
            unique case (w_cmd)
               CMD_ACT: begin
                  if (r_bank_open[sdr.sdr_ba]) r_err <= 1'b1;
                  r_bank_open[sdr.sdr_ba] <= 1'b1;
                  r_open_row[sdr.sdr_ba]  <= sdr.sdr_addr[ROW_W-1:0];
               end
               CMD_PRE: begin
                  if (sdr.sdr_addr[10]) r_bank_open <= '0;
                  else                  r_bank_open[sdr.sdr_ba] <= 1'b0;
               end
               CMD_MRS: begin
                  r_mode <= sdr.sdr_addr;
                  if ((sdr.sdr_addr[6:4] != 3'd2) && (sdr.sdr_addr[6:4] != 3'd3)) r_err <= 1'b1;
               end
               CMD_REF: begin
                  r_rfsh <= r_rfsh + 16'd1;
                  if (|r_bank_open) r_err <= 1'b1;
               end
               CMD_RD, CMD_WR: begin
                  if (!r_bank_open[sdr.sdr_ba]) r_err <= 1'b1;
               end
               CMD_BST, CMD_NOP: ;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bst_ba    <= '0;
         r_bst_row   <= '0;
         r_bst_start <= '0;
         r_bst_cnt   <= '0;
         r_bst_last  <= '0;
         r_bst_ap    <= 1'b0;
      end else if (w_beat) begin
         r_bst_ba    <= w_ba;
         r_bst_row   <= w_row;
         r_bst_start <= w_start;
         r_bst_cnt   <= w_cnt_nxt;
         r_bst_last  <= w_last;
         r_bst_ap    <= w_ap;
      end
   end

   // NOTE: the storage array has no reset; its contents are undefined until written.
   always_ff @(posedge clk) begin
      if (w_beat && w_beat_wr && !sdr.sdr_dqm) r_mem[w_idx] <= sdr.sdr_din;
   end

   // A WRITE squashes every in-flight read beat and drops the bus at its own edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_p1    <= '0;
         r_p2    <= '0;
         r_dqm_d <= 1'b0;
         r_dout  <= '0;
         r_doe   <= 1'b0;
      end else if (sdr.sdr_cke) begin
         r_dqm_d <= sdr.sdr_dqm;
         r_p1    <= '{vld: w_beat && !w_beat_wr, cl2: w_cl2, idx: w_idx};
         if (w_new_wr || !(r_p1.vld && !r_p1.cl2)) r_p2 <= '0;
         else                                       r_p2 <= r_p1;
         if (w_new_wr) begin
            r_doe <= 1'b0;
         end else if (w_out_vld) begin
            r_dout <= r_mem[w_out_idx];
            r_doe  <= !r_dqm_d;
         end else begin
            r_doe <= 1'b0;
         end
      end
   end

   assign sdr.sdr_dout = r_dout;
   assign sdr.sdr_doe  = r_doe;
   assign mode_reg     = r_mode;
   assign rfsh_cnt     = r_rfsh;
   assign cmd_err      = r_err;
endmodule

// File: tb/tb_sdram_dev_lite.sv
// Directed bench for sdram_dev_lite: stimulus pushes expected read beats (data and sample
// edge) into a scoreboard; a negedge monitor pops and compares whenever the device drives.
module tb_sdram_dev_lite;
   localparam logic [2:0] C_MRS = 3'b000;
   localparam logic [2:0] C_REF = 3'b001;
   localparam logic [2:0] C_ACT = 3'b011;
   localparam logic [2:0] C_WR  = 3'b100;
   localparam logic [2:0] C_RD  = 3'b101;
   localparam logic [2:0] C_NOP = 3'b111;

   typedef struct {
      logic [7:0] data;
      int         edge_n;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [12:0] mode_reg;
   logic [15:0] rfsh_cnt;
   logic        cmd_err;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   int          t;
   int          t_ign;
   exp_t        sb_q[$];

   sdram_dev_lite_if sdr_if();

   sdram_dev_lite #(.COL_W(8), .ROW_W(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .sdr      (sdr_if.slave),
      .mode_reg (mode_reg),
      .rfsh_cnt (rfsh_cnt),
      .cmd_err  (cmd_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [7:0] d, input int e);
      exp_t x;
      x.data   = d;
      x.edge_n = e;
      sb_q.push_back(x);
   endtask

   // The controller samples at the next rising edge only when cke is high there
   always @(negedge clk) begin
      if (!reset && sdr_if.sdr_cke && sdr_if.sdr_doe) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL rd_unexpected actual=%0h expected=no_beat (edge %0d)",
                     sdr_if.sdr_dout, cyc + 1);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("rd_data", {24'd0, sdr_if.sdr_dout}, {24'd0, e.data});
            check("rd_edge", cyc + 1, e.edge_n);
         end
      end
   end

   task automatic idle_bus();
      sdr_if.sdr_cs_n  = 1'b1;
      sdr_if.sdr_ras_n = 1'b1;
      sdr_if.sdr_cas_n = 1'b1;
      sdr_if.sdr_we_n  = 1'b1;
      sdr_if.sdr_dqm   = 1'b0;
   endtask

   task automatic issue(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] addr,
                        input logic [7:0] din, input logic dqm, output int te);
      sdr_if.sdr_cs_n = 1'b0;
      {sdr_if.sdr_ras_n, sdr_if.sdr_cas_n, sdr_if.sdr_we_n} = c;
      sdr_if.sdr_ba   = ba;
      sdr_if.sdr_addr = addr;
      sdr_if.sdr_din  = din;
      sdr_if.sdr_dqm  = dqm;
      @(posedge clk);
      #1;
      te = cyc;
      idle_bus();
   endtask

   task automatic nop(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      idle_bus();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] bv [8];
      logic [7:0] dv [8];
      bv = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7};
      dv = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hD6, 8'hD7};
      reset           = 1'b1;
      sdr_if.sdr_cke  = 1'b1;
      sdr_if.sdr_ba   = '0;
      sdr_if.sdr_addr = '0;
      sdr_if.sdr_din  = '0;
      idle_bus();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_doe",   sdr_if.sdr_doe, 0);
      check("rst_dout",  sdr_if.sdr_dout, 0);
      check("rst_err",   cmd_err, 0);
      check("rst_rfsh",  rfsh_cnt, 0);
      check("rst_mode",  mode_reg, 13'h032);

      // CL2 BL4: write A0..A3 at col 0x10, read back
      issue(C_MRS, 2'd0, 13'h022, 8'h00, 1'b0, t_ign);
      check("mode_022", mode_reg, 13'h022);
      issue(C_ACT, 2'd1, 13'd3, 8'h00, 1'b0, t_ign);
      issue(C_WR,  2'd1, 13'h010, 8'hA0, 1'b0, t_ign);
      issue(C_NOP, 2'd0, 13'h000, 8'hA1, 1'b0, t_ign);
      issue(C_NOP, 2'd0, 13'h000, 8'hA2, 1'b0, t_ign);
      issue(C_NOP, 2'd0, 13'h000, 8'hA3, 1'b0, t_ign);
      issue(C_RD,  2'd1, 13'h010, 8'h00, 1'b0, t);
      for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), t + 2 + i);
      nop(8);

      // CL3 BL8: fill cols 08..0F, then read from 0E with block wrap
      issue(C_MRS, 2'd0, 13'h033, 8'h00, 1'b0, t_ign);
      issue(C_WR,  2'd1, 13'h008, bv[0], 1'b0, t_ign);
      for (int i = 1; i < 8; i++) issue(C_NOP, 2'd0, 13'h000, bv[i], 1'b0, t_ign);
      issue(C_RD,  2'd1, 13'h00E, 8'h00, 1'b0, t);
      push(8'hB6, t + 3);
      push(8'hB7, t + 4);
      for (int i = 0; i < 6; i++) push(bv[i], t + 5 + i);
      nop(12);

      // Write mask on beat 2, then read mask: dqm at READ+1 hides the beat sampled at READ+3
      issue(C_MRS, 2'd0, 13'h022, 8'h00, 1'b0, t_ign);
      issue(C_WR,  2'd1, 13'h010, 8'hC0, 1'b0, t_ign);
      issue(C_NOP, 2'd0, 13'h000, 8'hC1, 1'b0, t_ign);
      issue(C_NOP, 2'd0, 13'h000, 8'hC2, 1'b1, t_ign);
      issue(C_NOP, 2'd0, 13'h000, 8'hC3, 1'b0, t_ign);
      issue(C_RD,  2'd1, 13'h010, 8'h00, 1'b0, t);
      push(8'hC0, t + 2);
      push(8'hC1, t + 3);
      push(8'hA2, t + 4);
      push(8'hC3, t + 5);
      nop(8);
      issue(C_RD,  2'd1, 13'h010, 8'h00, 1'b0, t);
      push(8'hC0, t + 2);
      push(8'hA2, t + 4);
      push(8'hC3, t + 5);
      issue(C_NOP, 2'd0, 13'h000, 8'h00, 1'b1, t_ign);
      nop(8);

      // Protocol violations and refresh counting
      do_reset();
      check("err_clear", cmd_err, 0);
      issue(C_REF, 2'd0, 13'h000, 8'h00, 1'b0, t_ign);
      check("rfsh_one", rfsh_cnt, 1);
      check("ref_closed_ok", cmd_err, 0);
      issue(C_REF, 2'd0, 13'h000, 8'h00, 1'b0, t_ign);
      check("rfsh_two", rfsh_cnt, 2);
      issue(C_ACT, 2'd0, 13'h000, 8'h00, 1'b0, t_ign);
      check("act_first_ok", cmd_err, 0);
      issue(C_ACT, 2'd0, 13'h001, 8'h00, 1'b0, t_ign);
      check("act_open_err", cmd_err, 1);
      nop(3);
      check("err_sticky", cmd_err, 1);
      do_reset();
      issue(C_ACT, 2'd2, 13'h000, 8'h00, 1'b0, t_ign);
      issue(C_REF, 2'd0, 13'h000, 8'h00, 1'b0, t_ign);
      check("ref_open_err", cmd_err, 1);
      check("ref_open_cnt", rfsh_cnt, 1);
      do_reset();
      issue(C_RD,  2'd2, 13'h010, 8'h00, 1'b0, t_ign);
      check("rd_closed_err", cmd_err, 1);
      nop(6);

      // BL8 read interrupted by a write at beat 3, then auto-precharge read
      do_reset();
      issue(C_MRS, 2'd0, 13'h033, 8'h00, 1'b0, t_ign);
      issue(C_ACT, 2'd1, 13'd3, 8'h00, 1'b0, t_ign);
      issue(C_RD,  2'd1, 13'h008, 8'h00, 1'b0, t);
      push(8'hB0, t + 3);
      nop(2);
      issue(C_WR,  2'd1, 13'h010, dv[0], 1'b0, t_ign);
      for (int i = 1; i < 8; i++) issue(C_NOP, 2'd0, 13'h000, dv[i], 1'b0, t_ign);
      nop(4);
      issue(C_RD,  2'd1, 13'h410, 8'h00, 1'b0, t);
      for (int i = 0; i < 8; i++) push(dv[i], t + 3 + i);
      nop(12);
      check("ap_no_err", cmd_err, 0);
      issue(C_RD,  2'd1, 13'h010, 8'h00, 1'b0, t_ign);
      check("ap_closed_err", cmd_err, 1);
      nop(6);

      // cke low for 3 cycles mid-burst: beat D1 held, nothing lost
      do_reset();
      issue(C_MRS, 2'd0, 13'h033, 8'h00, 1'b0, t_ign);
      issue(C_ACT, 2'd1, 13'd3, 8'h00, 1'b0, t_ign);
      issue(C_RD,  2'd1, 13'h010, 8'h00, 1'b0, t);
      push(dv[0], t + 3);
      for (int i = 1; i < 8; i++) push(dv[i], t + 6 + i);
      nop(3);
      sdr_if.sdr_cke = 1'b0;
      nop(1);
      check("cke_hold_dout", sdr_if.sdr_dout, 8'hD1);
      check("cke_hold_doe",  sdr_if.sdr_doe, 1);
      nop(2);
      sdr_if.sdr_cke = 1'b1;
      nop(12);

      // Reset in the middle of a read burst
      issue(C_RD,  2'd1, 13'h010, 8'h00, 1'b0, t);
      push(dv[0], t + 3);
      push(dv[1], t + 4);
      nop(4);
      check("mid_burst_doe", sdr_if.sdr_doe, 1);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_doe",  sdr_if.sdr_doe, 0);
      check("async_rst_dout", sdr_if.sdr_dout, 0);
      check("async_rst_mode", mode_reg, 13'h032);
      check("async_rst_err",  cmd_err, 0);
      check("async_rst_rfsh", rfsh_cnt, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      nop(8);
      check("sb_empty", sb_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
